// File: rtl/axi_bram_slave.sv
// AXI4 (INCR-only, 128-bit) slave backed by a byte-writable block RAM.
// The write and read channels run as independent FSMs sharing one memory array.
module axi_bram_slave #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [3:0]   s_axi_awid,
    input  logic [27:0]  s_axi_awaddr,
    input  logic [7:0]   s_axi_awlen,
    input  logic         s_axi_awvalid,
    output logic         s_axi_awready,
    input  logic [127:0] s_axi_wdata,
    input  logic [15:0]  s_axi_wstrb,
    input  logic         s_axi_wlast,
    input  logic         s_axi_wvalid,
    output logic         s_axi_wready,
    output logic [3:0]   s_axi_bid,
    output logic [1:0]   s_axi_bresp,
    output logic         s_axi_bvalid,
    input  logic         s_axi_bready,
    input  logic [3:0]   s_axi_arid,
    input  logic [27:0]  s_axi_araddr,
    input  logic [7:0]   s_axi_arlen,
    input  logic         s_axi_arvalid,
    output logic         s_axi_arready,
    output logic [3:0]   s_axi_rid,
    output logic [127:0] s_axi_rdata,
    output logic [1:0]   s_axi_rresp,
    output logic         s_axi_rlast,
    output logic         s_axi_rvalid,
    input  logic         s_axi_rready
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned DW    = 128;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned AW    = DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    wstate_t        r_wstate;
    logic           r_awready;
    logic           r_wready;
    logic           r_bvalid;
    logic [3:0]     r_bid;
    logic [1:0]     r_bresp;
    logic [AW-1:0]  r_widx;
    logic [7:0]     r_wcnt;

    rstate_t        r_rstate;
    logic           r_arready;
    logic           r_rvalid;
    logic           r_rlast;
    logic [3:0]     r_rid;
    logic [AW-1:0]  r_ridx;
    logic [7:0]     r_rcnt;
    logic [DW-1:0]  r_rdata;

    logic [DW-1:0]  r_mem [DEPTH];

    logic           w_wr;
    logic           w_fetch;
    logic           w_unused;

    assign w_wr = r_wready && s_axi_wvalid;
    // A new beat is fetched on entry to R_FETCH or on a non-final R handshake (back-to-back beats).
    assign w_fetch = (r_rstate == R_FETCH) ||
                     ((r_rstate == R_DATA) && r_rvalid && s_axi_rready && !r_rlast);

    // Address bits outside the word index are ignored, so the memory aliases.
    assign w_unused = ^{s_axi_awaddr[27:AW+4], s_axi_awaddr[3:0],
                        s_axi_araddr[27:AW+4], s_axi_araddr[3:0]};

    // Write channel FSM; r_wcnt holds beats remaining minus one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 4'd0;
            r_bresp   <= RESP_OKAY;
            r_widx    <= '0;
            r_wcnt    <= 8'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && s_axi_awvalid) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= s_axi_awid;
                        r_widx    <= s_axi_awaddr[AW+3:4];
                        r_wcnt    <= s_axi_awlen;
                    end
                end
                W_DATA: begin
                    if (w_wr) begin
                        r_widx <= r_widx + AW'(1);
                        r_wcnt <= r_wcnt - 8'd1;
                        if ((r_wcnt == 8'd0) || s_axi_wlast) begin
                            r_wstate <= W_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= ((r_wcnt == 8'd0) && s_axi_wlast) ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Synchronous read port; sees pre-write contents on a same-cycle write.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata <= '0;
        end else if (w_fetch) begin
            r_rdata <= r_mem[r_ridx];
        end
    end

    // Read channel FSM; r_rcnt holds beats remaining minus one before each fetch.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= 4'd0;
            r_ridx    <= '0;
            r_rcnt    <= 8'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && s_axi_arvalid) begin
                        r_rstate  <= R_FETCH;
                        r_arready <= 1'b0;
                        r_rid     <= s_axi_arid;
                        r_ridx    <= s_axi_araddr[AW+3:4];
                        r_rcnt    <= s_axi_arlen;
                    end
                end
                R_FETCH: begin
                    r_rstate <= R_DATA;
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rcnt == 8'd0);
                    r_ridx   <= r_ridx + AW'(1);
                    r_rcnt   <= r_rcnt - 8'd1;
                end
                R_DATA: begin
                    if (r_rvalid && s_axi_rready) begin
                        if (r_rlast) begin
                            r_rstate  <= R_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rlast <= (r_rcnt == 8'd0);
                            r_ridx  <= r_ridx + AW'(1);
                            r_rcnt  <= r_rcnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: doc/axi_bram_slave.md
AXI_BRAM_SLAVE -- requirements
Module: axi_bram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: memory holds 2**DEPTH_LOG2 words of 128 bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_axi_awid  input  4  write burst ID.
REQ-005 SHALL have port s_axi_awaddr  input  28  write byte address.
REQ-006 SHALL have port s_axi_awlen  input  8  write beats minus one.
REQ-007 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-008 SHALL have port s_axi_awready  output  1  write address accepted.
REQ-009 SHALL have port s_axi_wdata  input  128  write beat data.
REQ-010 SHALL have port s_axi_wstrb  input  16  byte enables; bit i covers byte i.
REQ-011 SHALL have port s_axi_wlast  input  1  final write beat marker.
REQ-012 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-013 SHALL have port s_axi_wready  output  1  write data accepted.
REQ-014 SHALL have port s_axi_bid  output  4  response ID, equals captured awid.
REQ-015 SHALL have port s_axi_bresp  output  2  00 OKAY, 10 SLVERR.
REQ-016 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-017 SHALL have port s_axi_bready  input  1  write response accepted.
REQ-018 SHALL have port s_axi_arid  input  4  read burst ID.
REQ-019 SHALL have port s_axi_araddr  input  28  read byte address.
REQ-020 SHALL have port s_axi_arlen  input  8  read beats minus one.
REQ-021 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-022 SHALL have port s_axi_arready  output  1  read address accepted.
REQ-023 SHALL have ports s_axi_rid (output 4, captured arid), s_axi_rdata (output 128), s_axi_rresp (output 2, always 00), s_axi_rlast (output 1), s_axi_rvalid (output 1), s_axi_rready (input 1).

Function
REQ-024 SHALL run write and read paths as independent FSMs sharing one memory; all beats 16 bytes, INCR only.
REQ-025 Word index SHALL be addr[DEPTH_LOG2+3:4], +1 per beat, wrapping modulo 2**DEPTH_LOG2; upper address bits ignored (aliasing).
REQ-026 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-027 AW handshake in cycle N SHALL capture awid/awaddr/awlen and enter W_DATA at N+1 (awready low at N+1).
REQ-028 Each W handshake SHALL write enabled bytes of wdata to the current index; disabled bytes unchanged.
REQ-029 W_DATA SHALL exit to W_RESP after beat awlen+1; bresp=00 if wlast was high on exactly that beat, else 10; an early wlast SHALL also end the burst with 10.
REQ-030 W_RESP SHALL hold bvalid/bid/bresp stable until bready; W_IDLE (awready=1) the following cycle.
REQ-031 Read FSM SHALL be R_IDLE -> R_FETCH -> R_DATA; arready=1 only in R_IDLE; memory read synchronous (one-cycle latency).
REQ-032 AR handshake in cycle N SHALL give first rvalid at N+2; rdata/rid/rlast stable while rvalid and not rready.
REQ-033 On R handshake: last beat -> R_IDLE; otherwise next beat presented at most 2 cycles later (back-to-back allowed); rlast high only on beat arlen+1.
REQ-034 Same-cycle write and fetch of same index SHALL return old data (read-first).
REQ-035 awlen=0 / arlen=0 SHALL be single-beat bursts; awlen=255 SHALL write 256 beats.

Reset
REQ-036 While nrst=0: all outputs 0, both FSMs idle, any burst abandoned; memory contents not cleared; awready/arready rise the first cycle after nrst=1.

Verification
REQ-037 AW(id=3,addr=0x40,len=0), W(data=0xA5,strb=FFFF,last=1) -> bvalid one cycle after W handshake, bid=3, bresp=00; AR addr 0x40 -> rvalid 2 cycles after AR, rdata=0xA5, rlast=1.
REQ-038 4-beat write at index 2**DEPTH_LOG2-2 -> beats 3,4 land at indices 0,1; 4-beat read of same returns all four, rlast on beat 4.
REQ-039 Write with wstrb=0x0001 over existing 0x..FFFF -> only byte 0 replaced.
REQ-040 awlen=3 with wlast on beat 2 -> burst ends, bresp=10; wlast absent on beat 4 -> bresp=10.
REQ-041 rready/bready held low 5 cycles -> outputs stable; simultaneous write/read bursts both complete correctly.
REQ-042 nrst pulsed low mid-read burst -> rvalid=0 immediately; arready=1 first cycle after release; memory retains data.
